uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Buffered UART transmitter for the MIPS150 serial link. The CPU side pushes bytes with the same DataIn/DataInValid/DataInReady handshake that the CPU-to-UART path uses. Bytes are queued in a small FIFO and serialized 8N1, LSB first, on SOut toward FPGA_SERIAL_TX. This lets software write short bursts without polling between bytes.

Parameters:
CLOCK_FREQ  100_000_000  system clock frequency in Hz
BAUD_RATE   115_200      serial bit rate in bits/s
FIFO_DEPTH  8            queue entries; power of 2, at least 2

Ports:
Clock        input   1                      system clock; all logic updates on its rising edge
Reset        input   1                      synchronous, active-high reset
DataIn       input   8                      byte offered by the CPU side
DataInValid  input   1                      DataIn is valid this cycle
DataInReady  output  1                      FIFO can accept a byte this cycle
SOut         output  1                      serial line; idle high
Busy         output  1                      a frame is in flight or the FIFO is non-empty
Count        output  $clog2(FIFO_DEPTH)+1   number of bytes queued, not counting the frame in flight

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. Everything updates on the rising edge of Clock.
- Reset values: SOut=1, Busy=0, Count=0, FIFO pointers=0, FSM in IDLE, bit counters=0.
- DataInReady is 0 while Reset is high.
- A Reset asserted mid-frame aborts the frame. SOut returns to 1 on the next edge and all queued bytes are discarded.
- SYMBOL = CLOCK_FREQ/BAUD_RATE, integer division, truncated. Every bit, including start and stop, is held for exactly SYMBOL cycles.
- Push: DataInReady = (Count != FIFO_DEPTH) && !Reset, decoded combinationally from registered state.
  - A byte is accepted on any edge where DataInValid && DataInReady. Count increments on that edge.
  - DataInValid while not ready is ignored. No data is lost on the line and no error is flagged.
- Pop: the FSM pops the FIFO head on an edge where the FSM is in IDLE, or finishing STOP, and Count != 0.
  - When push and pop occur on the same edge, Count is unchanged.
  - When Count = FIFO_DEPTH, DataInReady = 0 even if a pop happens that edge, so full is never overrun.
- FIFO pointers wrap modulo FIFO_DEPTH. Count distinguishes full from empty.
- FSM states:
  - IDLE: SOut=1. On pop, load the shift register and go to START.
  - START: SOut=0 for SYMBOL cycles, then go to DATA.
  - DATA: SOut = shift[0]. After each SYMBOL cycles, shift right. After 8 bits, go to STOP.
  - STOP: SOut=1 for SYMBOL cycles. At the end, pop and go to START if Count != 0; otherwise go to IDLE.
- Back-to-back frames have no idle gap between the stop bit and the next start bit.
- Latency: a byte pushed into an empty, idle block is accepted at edge k and popped at edge k+1. SOut falls after edge k+1. The full frame lasts 10*SYMBOL cycles.
- Busy = (state != IDLE) || (Count != 0).
- SOut is driven directly from a register, so the line is glitch-free.

Test Plan:
- Reset check: hold Reset for 3 cycles with DataInValid=1 -> SOut=1, DataInReady=0, Count=0, Busy=0 throughout. No push occurs.
- Single byte (CLOCK_FREQ=1000, BAUD_RATE=100, so SYMBOL=10): push 0xA5 at edge k.
  - SOut is low for cycles k+1..k+10.
  - Data bits 1,0,1,0,0,1,0,1 follow, 10 cycles each.
  - Stop bit is high for 10 cycles.
  - Busy drops to 0 after edge k+101.
- Back-to-back: push 0x00 then 0xFF on consecutive edges -> two 100-cycle frames with no gap. The second start bit begins the cycle after the first stop bit ends.
- Full FIFO (FIFO_DEPTH=8): push 10 bytes, 0x01..0x0A, while DataInValid is held high.
  - DataInReady drops when Count=8.
  - 0x0A is accepted only after the first pop.
  - Serial output order is 0x01..0x0A, with nothing dropped or duplicated.
- Simultaneous push/pop at Count=1, at the end of STOP -> Count stays 1. The new byte is sent after the current head.
- Reset mid-frame: assert Reset during DATA bit 3 of 0x3C, with 2 bytes queued.
  - After the next edge, SOut=1, Count=0, Busy=0.
  - No further frames are sent after Reset is released.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a serializer.
// SOut comes straight from a flop, so the line never glitches.
module uart_tx_fifo #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [7:0]                    DataIn,
    input  logic                          DataInValid,
    output logic                          DataInReady,
    output logic                          SOut,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   Count
);

    localparam int unsigned Symbol = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned SymW   = (Symbol > 1) ? $clog2(Symbol) : 1;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;

    localparam logic [SymW-1:0] SymLast = SymW'(Symbol - 1);
    localparam logic [CntW-1:0] Full    = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic [SymW-1:0] sym_cnt_q, sym_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            sout_q, sout_d;
    logic            push, pop, sym_end;

    // Ready looks only at registered state, so a same-edge pop cannot free a slot early.
    assign DataInReady = (count_q != Full) && !Reset;
    assign push        = DataInValid && DataInReady;
    assign sym_end     = (sym_cnt_q == SymLast);
    assign pop         = (count_q != '0) &&
                         ((state_q == StIdle) || ((state_q == StStop) && sym_end));

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset; Count and the pointers define which entries are live.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= DataIn;
        end
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StIdle;
            sym_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sout_q    <= 1'b1;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sout_q    <= sout_d;
            count_q   <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d   = StStart;
                    shift_d   = mem_q[rd_ptr_q];
                    sym_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            StStart: begin
                if (sym_end) begin
                    sym_cnt_d = '0;
                    state_d   = StData;
                end else begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (sym_end) begin
                    sym_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (sym_end) begin
                    sym_cnt_d = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (pop) begin
                        state_d   = StStart;
                        shift_d   = mem_q[rd_ptr_q];
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: line level is decided from the upcoming state and registered.
    always_comb begin
        sout_d = 1'b1;
        unique case (state_d)
            StIdle:  sout_d = 1'b1;
            StStart: sout_d = 1'b0;
            StData:  sout_d = shift_d[0];
            StStop:  sout_d = 1'b1;
            default: sout_d = 1'b1;
        endcase
    end

    assign SOut  = sout_q;
    assign Count = count_q;
    assign Busy  = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pushed bytes are queued as expectations and
// a serial monitor decodes SOut frames and compares them in order.
module tb_uart_tx_fifo;

    logic       clk;
    logic       Reset;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;
    logic       SOut;
    logic       Busy;
    logic [3:0] Count;

    uart_tx_fifo #(
        .CLOCK_FREQ(1000),
        .BAUD_RATE (100),
        .FIFO_DEPTH(8)
    ) dut (
        .Clock      (clk),
        .Reset      (Reset),
        .DataIn     (DataIn),
        .DataInValid(DataInValid),
        .DataInReady(DataInReady),
        .SOut       (SOut),
        .Busy       (Busy),
        .Count      (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;
    int frames = 0;
    int sout_low = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Serial monitor: bit i of a frame spans monitor ticks 10*i .. 10*i+9.
    logic       mon_act = 1'b0;
    int         mon_t = 0;
    int         mon_start = 0;
    logic       prev_sout = 1'b1;
    logic [7:0] rx = '0;
    always @(negedge clk) begin
        if (SOut === 1'b0) sout_low++;
        if (Reset === 1'b1) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (prev_sout === 1'b1 && SOut === 1'b0) begin
                mon_act   = 1'b1;
                mon_t     = 0;
                mon_start = edge_n;
            end
        end else begin
            mon_t++;
            if (mon_t == 5) begin
                check("start_bit", {31'd0, SOut}, 32'd0);
            end else if (mon_t >= 15 && mon_t <= 85 && (mon_t % 10) == 5) begin
                rx[(mon_t - 15) / 10] = SOut;
            end else if (mon_t == 95) begin
                check("stop_bit", {31'd0, SOut}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_unexpected: got byte %0h required no frame", rx);
                end else begin
                    check("rx_byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
                end
                frames++;
                starts.push_back(mon_start);
                mon_act = 1'b0;
            end
        end
        prev_sout = SOut;
    end

    task automatic go_edge(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_neg(input int e);
        do @(negedge clk); while (edge_n < e);
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge with valid still high.
    task automatic push_byte(input logic [7:0] b, output int acc);
        int   guard;
        logic r;
        guard = 0;
        DataIn = b;
        DataInValid = 1'b1;
        forever begin
            @(negedge clk);
            r = DataInReady;
            @(posedge clk);
            #1;
            if (r) break;
            guard++;
            if (guard > 3000) begin
                n_cmp++;
                n_err++;
                $display("FAIL push_timeout: got no accept required accept of %0h", b);
                break;
            end
        end
        acc = edge_n;
        exp_q.push_back(b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish by 1000000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        int k, a, f0, l0;
        Reset = 1'b1;
        DataInValid = 1'b1;
        DataIn = 8'h55;

        // Reset held with valid asserted: nothing may be accepted.
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check("rst_sout", {31'd0, SOut}, 32'd1);
            check("rst_ready", {31'd0, DataInReady}, 32'd0);
            check("rst_count", {28'd0, Count}, 32'd0);
            check("rst_busy", {31'd0, Busy}, 32'd0);
        end
        @(posedge clk);
        #1;
        Reset = 1'b0;
        DataInValid = 1'b0;
        @(negedge clk);
        check("post_rst_count", {28'd0, Count}, 32'd0);
        check("post_rst_ready", {31'd0, DataInReady}, 32'd1);
        @(posedge clk);
        #1;

        // Single byte 0xA5.
        f0 = frames;
        push_byte(8'hA5, k);
        DataInValid = 1'b0;
        check("single_count_k", {28'd0, Count}, 32'd1);
        wait_neg(k + 1);
        check("single_count_k1", {28'd0, Count}, 32'd0);
        check("single_sout_k1", {31'd0, SOut}, 32'd0);
        wait_neg(k + 100);
        check("single_busy_k100", {31'd0, Busy}, 32'd1);
        check("single_stop_k100", {31'd0, SOut}, 32'd1);
        wait_neg(k + 101);
        check("single_busy_k101", {31'd0, Busy}, 32'd0);
        check("single_frames", frames, f0 + 1);
        check("single_start", starts[starts.size() - 1], k + 1);

        // Back-to-back 0x00 then 0xFF.
        go_edge(edge_n + 5);
        f0 = frames;
        push_byte(8'h00, k);
        push_byte(8'hFF, a);
        DataInValid = 1'b0;
        check("b2b_acc2", a, k + 1);
        wait_neg(k + 205);
        check("b2b_frames", frames, f0 + 2);
        check("b2b_start1", starts[starts.size() - 2], k + 1);
        check("b2b_start2", starts[starts.size() - 1], k + 101);
        check("b2b_busy", {31'd0, Busy}, 32'd0);

        // Fill the FIFO with 0x01..0x0A while valid stays high.
        go_edge(edge_n + 5);
        f0 = frames;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) begin
                check("full_count", {28'd0, Count}, 32'd8);
                check("full_ready", {31'd0, DataInReady}, 32'd0);
            end
            push_byte(8'(i), a);
            if (i == 1) k = a;
            if (i == 9) check("full_acc9", a, k + 8);
            if (i == 10) check("full_acc10", a, k + 102);
        end
        DataInValid = 1'b0;
        wait_neg(k + 1005);
        check("full_frames", frames, f0 + 10);
        check("full_drained", exp_q.size(), 0);
        check("full_last_start", starts[starts.size() - 1], k + 901);

        // Push coinciding with the pop at the end of a stop bit, Count = 1.
        go_edge(edge_n + 5);
        f0 = frames;
        push_byte(8'h11, k);
        push_byte(8'h22, a);
        DataInValid = 1'b0;
        go_edge(k + 100);
        check("sim_count_before", {28'd0, Count}, 32'd1);
        push_byte(8'h33, a);
        DataInValid = 1'b0;
        check("sim_acc", a, k + 101);
        check("sim_count_after", {28'd0, Count}, 32'd1);
        wait_neg(k + 305);
        check("sim_frames", frames, f0 + 3);
        check("sim_start3", starts[starts.size() - 1], k + 201);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        go_edge(edge_n + 5);
        push_byte(8'h3C, k);
        push_byte(8'h01, a);
        push_byte(8'h02, a);
        DataInValid = 1'b0;
        go_edge(k + 45);
        check("mid_count", {28'd0, Count}, 32'd2);
        check("mid_sout_bit3", {31'd0, SOut}, 32'd1);
        Reset = 1'b1;
        wait_neg(k + 46);
        check("mid_rst_sout", {31'd0, SOut}, 32'd1);
        check("mid_rst_count", {28'd0, Count}, 32'd0);
        check("mid_rst_busy", {31'd0, Busy}, 32'd0);
        check("mid_rst_ready", {31'd0, DataInReady}, 32'd0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        exp_q.delete();
        f0 = frames;
        l0 = sout_low;
        wait_neg(edge_n + 300);
        check("mid_no_frames", frames, f0);
        check("mid_line_idle", sout_low, l0);
        check("mid_busy_after", {31'd0, Busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
